systolic_array_ctrl: RTL and testbench
======================================

# systolic_array_ctrl

Sequencer for the weight/activation systolic array. It accepts a matmul job of K inner-product steps and issues operand-memory reads one k-index per cycle. It skews the returned A column and B row vectors diagonally, with lane i delayed i cycles, drives the array enable and accumulator clear, and pulses `done` once every PE accumulator holds the final result. It sits between the operand buffers and the array, and owns all array timing.

## Interface
- `BITS`, 8, operand width (signed) per lane
- `DIM`, 32, array dimension; number of A lanes and of B lanes
- `KW`, 16, width of the K length and read address
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  job request; sampled only in IDLE
- `k_len`  in  KW  number of inner-product steps K; sampled with `start`
- `busy`  out  1  high from the cycle after `start` is accepted through the `done` cycle
- `rd_en`  out  1  operand read strobe to both the A and B buffers
- `rd_addr`  out  KW  k index being read (0..K-1)
- `a_col`  in  DIM x BITS  A column k, valid the cycle after `rd_en`
- `b_row`  in  DIM x BITS  B row k, valid the cycle after `rd_en`
- `arr_en`  out  1  array enable
- `arr_clr`  out  1  one-cycle accumulator clear to every PE
- `A_out`  out  DIM x BITS  skewed A lanes to the array west edge
- `B_out`  out  DIM x BITS  skewed B lanes to the array north edge
- `done`  out  1  one-cycle pulse; array results are stable and readable

## Operation
- FSM states: IDLE, CLEAR, FEED, DRAIN, DONE.
- IDLE, `start`=1, `k_len`≠0: latch K, go to CLEAR.
- IDLE, `start`=1, `k_len`=0: go directly to DONE. This produces no reads and no clear.
- CLEAR: `arr_clr`=1 for exactly one cycle. Go to FEED; the k counter is 0.
- FEED: `rd_en`=1, `rd_addr`=k, and k increments each cycle. After k=K-1 is issued, go to DRAIN; the drain counter is 0.
- DRAIN: `rd_en`=0. The counter runs 0..2*DIM-1. After the last count, go to DONE.
- DONE: `done`=1 for one cycle, then return to IDLE.
- `arr_en`=1 in every FEED and DRAIN cycle and 0 otherwise.
- `start` is ignored outside IDLE. A `start` in the DONE cycle is also ignored.
- Operand capture uses a valid bit: a one-cycle-delayed `rd_en`.
  - Valid cycle: `a_col`/`b_row` are registered into skew stage 0.
  - Non-valid cycle: zeros are registered into stage 0.
  - The zero insertion keeps the PEs from accumulating garbage.
- Skew: lane i passes through i additional registers, so `A_out[i]` = stage0_A[i] delayed i cycles. B is skewed identically.
  - Stage counts per lane: lane 0 has 1 register, lane DIM-1 has DIM registers.
- There is no arithmetic in the block. Operands pass through unmodified, with signedness preserved.
- K counter wrap: K up to 2^KW-1 is legal. The counter compares against K-1 and never wraps.

## Timing
- Reset values: `busy`, `rd_en`, `arr_en`, `arr_clr` and `done` are 0. `rd_addr` is 0. All skew registers, and therefore `A_out` and `B_out`, are 0. The state is IDLE.
- Reset mid-job: the next cycle is IDLE with all outputs at reset values. No `done` is issued, and the job is lost.
- Let s be the cycle in which `start` is accepted.
- CLEAR occurs at s+1.
- FEED occupies t0=s+2 through t0+K-1.
- Operand k appears on `A_out[i]`/`B_out[i]` at cycle t0+k+2+i.
- DRAIN occupies t0+K through t0+K+2*DIM-1.
- `done` fires at t0+K+2*DIM = s+K+2*DIM+2.
- The drain length covers the last operand reaching lane DIM-1 and propagating DIM-1 PE hops. It also covers the final PE accumulate.
- The earliest next `start` acceptance is the cycle after `done`.
- K=0 case: `busy`=1 and `done`=1 both occur at s+1.

## Test plan
- Reset, then idle: all outputs are 0. `start` with DIM=4, K=3 at cycle s produces:
  - `arr_clr` at s+1;
  - `rd_en` at s+2..s+4 with `rd_addr` 0,1,2;
  - `arr_en` at s+2..s+12;
  - `done` only at s+13.
- Skew check, DIM=4: return `a_col`=`b_row`={k+1,k+1,k+1,k+1} per k. `A_out[3]` must show 1,2,3 at cycles s+7,s+8,s+9 and 0 elsewhere. `A_out[0]` must show 1,2,3 at s+4..s+6.
- Full-result check: run the controller plus array, DIM=4, K=4, with random signed operands including -128. Every Cout at `done` must equal the reference A×B, computed in 16-bit signed.
- `k_len`=0: `done` at s+1, with no `rd_en`, no `arr_clr` and no `arr_en`.
- `start` held high continuously, K=2: jobs are accepted every 2+2*DIM+2+1 cycles. `start` during busy and during DONE has no effect.
- `rst` asserted during DRAIN: the next cycle has `busy`=0, `arr_en`=0 and all `A_out`/`B_out` at 0. No `done` ever follows, and a fresh `start` runs normally.

Source files
------------

// File: rtl/systolic_array_ctrl.sv
// Sequencer for the weight/activation systolic array: issues one operand read per k,
// diagonally skews the returned A/B vectors and frames the array enable, clear and done.
module systolic_array_ctrl #(
   parameter int unsigned BITS = 8,
   parameter int unsigned DIM  = 32,
   parameter int unsigned KW   = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [KW-1:0]             k_len,
   output logic                      busy,
   output logic                      rd_en,
   output logic [KW-1:0]             rd_addr,
   input  logic [DIM-1:0][BITS-1:0]  a_col,
   input  logic [DIM-1:0][BITS-1:0]  b_row,
   output logic                      arr_en,
   output logic                      arr_clr,
   output logic [DIM-1:0][BITS-1:0]  A_out,
   output logic [DIM-1:0][BITS-1:0]  B_out,
   output logic                      done
);

   localparam int unsigned DW = $clog2(2 * DIM);

   typedef enum logic [2:0] {StIdle, StClear, StFeed, StDrain, StDone} state_e;

   state_e        state_q;
   logic [KW-1:0] k_last_q;
   logic [DW-1:0] drain_q;
   logic          valid_q;

   // rd_addr doubles as the k counter; it stops at K-1 so it never wraps.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         k_last_q <= '0;
         drain_q  <= '0;
         busy     <= 1'b0;
         rd_en    <= 1'b0;
         rd_addr  <= '0;
         arr_en   <= 1'b0;
         arr_clr  <= 1'b0;
         done     <= 1'b0;
      end else begin
         arr_clr <= 1'b0;
         done    <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  busy <= 1'b1;
                  if (k_len == '0) begin
                     state_q <= StDone;
                     done    <= 1'b1;
                  end else begin
                     state_q  <= StClear;
                     k_last_q <= k_len - KW'(1);
                     arr_clr  <= 1'b1;
                  end
               end
            end
            StClear: begin
               state_q <= StFeed;
               rd_en   <= 1'b1;
               rd_addr <= '0;
               arr_en  <= 1'b1;
            end
            StFeed: begin
               if (rd_addr == k_last_q) begin
                  state_q <= StDrain;
                  rd_en   <= 1'b0;
                  drain_q <= '0;
               end else begin
                  rd_addr <= rd_addr + KW'(1);
               end
            end
            StDrain: begin
               if (drain_q == DW'(2 * DIM - 1)) begin
                  state_q <= StDone;
                  arr_en  <= 1'b0;
                  done    <= 1'b1;
               end else begin
                  drain_q <= drain_q + DW'(1);
               end
            end
            StDone: begin
               state_q <= StIdle;
               busy    <= 1'b0;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // Operand data arrives one cycle after the read strobe.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
      end else begin
         valid_q <= rd_en;
      end
   end

   // Lane i holds i+1 registers; zeros enter stage 0 whenever no operand is valid.
   for (genvar i = 0; i < DIM; i++) begin : g_lane
      logic [BITS-1:0] a_sr_q [i+1];
      logic [BITS-1:0] b_sr_q [i+1];

      always_ff @(posedge clk) begin
         if (rst) begin
            for (int j = 0; j <= i; j++) begin
               a_sr_q[j] <= '0;
               b_sr_q[j] <= '0;
            end
         end else begin
            a_sr_q[0] <= valid_q ? a_col[i] : '0;
            b_sr_q[0] <= valid_q ? b_row[i] : '0;
            for (int j = 1; j <= i; j++) begin
               a_sr_q[j] <= a_sr_q[j-1];
               b_sr_q[j] <= b_sr_q[j-1];
            end
         end
      end

      assign A_out[i] = a_sr_q[i];
      assign B_out[i] = b_sr_q[i];
   end

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Scoreboard bench for systolic_array_ctrl (DIM=4) with a behavioural operand buffer
// and a behavioural 4x4 output-stationary PE array for end-to-end result checks.
module tb_systolic_array_ctrl;

   localparam int unsigned BITS = 8;
   localparam int unsigned DIM  = 4;
   localparam int unsigned KW   = 16;

   logic                     clk = 1'b0;
   logic                     rst = 1'b1;
   logic                     start = 1'b0;
   logic [KW-1:0]            k_len = '0;
   logic                     busy, rd_en, arr_en, arr_clr, done;
   logic [KW-1:0]            rd_addr;
   logic [DIM-1:0][BITS-1:0] a_col = '0;
   logic [DIM-1:0][BITS-1:0] b_row = '0;
   logic [DIM-1:0][BITS-1:0] A_out, B_out;

   systolic_array_ctrl #(.BITS(BITS), .DIM(DIM), .KW(KW)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .k_len   (k_len),
      .busy    (busy),
      .rd_en   (rd_en),
      .rd_addr (rd_addr),
      .a_col   (a_col),
      .b_row   (b_row),
      .arr_en  (arr_en),
      .arr_clr (arr_clr),
      .A_out   (A_out),
      .B_out   (B_out),
      .done    (done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int                       cyc;
      logic                     busy, rd, clr, en, dn;
      logic [KW-1:0]            addr;
      logic [DIM-1:0][BITS-1:0] a, b;
   } exp_t;

   typedef struct {
      int                         cyc;
      logic [DIM*DIM-1:0][15:0]   c;
   } res_t;

   exp_t exp_q[$];
   res_t res_q[$];
   int   n_checks = 0;
   int   n_fail = 0;

   // Operand buffers: mem_a[k][i] = A[i][k], mem_b[k][j] = B[k][j].
   logic signed [BITS-1:0] mem_a [8][DIM];
   logic signed [BITS-1:0] mem_b [8][DIM];

   task automatic check(input string name, input int c, input logic [63:0] act,
                        input logic [63:0] want);
      n_checks++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=%h expected=%h", name, c, act, want);
      end
   endtask

   // Expected per-cycle trace of a job accepted in cycle s, cycles s+1..s+upto.
   function automatic void push_job(input int s, input int kk, input int upto);
      exp_t e;
      int   last, k;
      last = (kk == 0) ? 1 : kk + 2 * DIM + 2;
      for (int c = 1; c <= last + 1 && c <= upto; c++) begin
         e.cyc  = s + c;
         e.busy = (c <= last);
         e.rd   = (kk > 0) && (c >= 2) && (c <= kk + 1);
         e.clr  = (kk > 0) && (c == 1);
         e.en   = (kk > 0) && (c >= 2) && (c <= kk + 2 * DIM + 1);
         e.dn   = (c == last);
         e.addr = KW'(c - 2);
         for (int i = 0; i < DIM; i++) begin
            k = c - 4 - i;
            e.a[i] = (k >= 0 && k < kk) ? mem_a[k][i] : '0;
            e.b[i] = (k >= 0 && k < kk) ? mem_b[k][i] : '0;
         end
         exp_q.push_back(e);
      end
   endfunction

   function automatic void push_idle(input int from, input int n);
      exp_t e;
      for (int c = 0; c < n; c++) begin
         e = '{cyc: from + c, busy: 1'b0, rd: 1'b0, clr: 1'b0, en: 1'b0, dn: 1'b0,
               addr: '0, a: '0, b: '0};
         exp_q.push_back(e);
      end
   endfunction

   // Operand buffer model: returns the addressed vectors one cycle after rd_en, garbage otherwise.
   logic          pv;
   logic [KW-1:0] pa;
   always begin
      @(negedge clk);
      pv = rd_en;
      pa = rd_addr;
      @(posedge clk);
      #1;
      for (int i = 0; i < DIM; i++) begin
         a_col[i] = pv ? mem_a[pa[2:0]][i] : BITS'(8'h55 + i);
         b_row[i] = pv ? mem_b[pa[2:0]][i] : BITS'(8'hA3 - i);
      end
   end

   // Output-stationary PE array: A flows east, B flows south, one hop per cycle.
   logic signed [BITS-1:0] ah [DIM][DIM];
   logic signed [BITS-1:0] bv [DIM][DIM];
   logic [15:0]            acc [DIM][DIM];
   always @(posedge clk) begin
      logic signed [BITS-1:0] ai, bi;
      logic signed [15:0]     prod;
      for (int i = 0; i < DIM; i++) begin
         for (int j = 0; j < DIM; j++) begin
            if (j == 0) ai = A_out[i];
            else        ai = ah[i][j-1];
            if (i == 0) bi = B_out[j];
            else        bi = bv[i-1][j];
            prod = ai * bi;
            ah[i][j] <= ai;
            bv[i][j] <= bi;
            if (rst || arr_clr) acc[i][j] <= '0;
            else if (arr_en)    acc[i][j] <= acc[i][j] + prod;
         end
      end
   end

   // Monitor: pops the expected record scheduled for this cycle and compares.
   exp_t me;
   res_t mr;
   always @(negedge clk) begin
      if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
         me = exp_q.pop_front();
         check("stale_record", cyc, 64'(me.cyc), 64'(cyc));
      end
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
         me = exp_q.pop_front();
         check("ctl{busy,rd_en,clr,en,done}", cyc, 64'({busy, rd_en, arr_clr, arr_en, done}),
               64'({me.busy, me.rd, me.clr, me.en, me.dn}));
         if (me.rd) check("rd_addr", cyc, 64'(rd_addr), 64'(me.addr));
         check("A_out", cyc, 64'(A_out), 64'(me.a));
         check("B_out", cyc, 64'(B_out), 64'(me.b));
      end
      if (res_q.size() > 0 && res_q[0].cyc == cyc) begin
         mr = res_q.pop_front();
         for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++)
               check("cout", cyc, 64'(acc[i][j]), 64'(mr.c[i*DIM+j]));
      end
   end

   task automatic wait_drain();
      int t = 0;
      while ((exp_q.size() > 0 || res_q.size() > 0) && t < 300) begin
         @(posedge clk);
         t++;
      end
      if (exp_q.size() > 0 || res_q.size() > 0) begin
         check("drain_timeout", cyc, 64'(exp_q.size() + res_q.size()), 64'(0));
         exp_q.delete();
         res_q.delete();
      end
      @(posedge clk);
      #1;
   endtask

   // Issues start for one cycle; k_len is then scrambled to prove it was latched.
   task automatic start_job(input int kk, output int s);
      s = cyc;
      start = 1'b1;
      k_len = KW'(kk);
      push_job(s, kk, 1000);
      @(posedge clk);
      #1;
      start = 1'b0;
      k_len = 16'd9;
   endtask

   int ta [DIM][4] = '{'{-128, 127, -1, 3}, '{5, -7, 100, -128},
                       '{0, 1, -2, 64}, '{-128, -128, -128, -128}};
   int tb [4][DIM] = '{'{-128, 2, 0, 1}, '{127, -3, 9, -128},
                       '{1, -1, 50, 7}, '{-2, 4, -128, 127}};

   initial begin
      int   s;
      res_t r;
      logic signed [15:0] sum, p;

      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      push_idle(cyc, 4);
      repeat (4) @(posedge clk);
      #1;

      // Skew job: every lane of A and B carries k+1; each C entry is 1+4+9 = 14.
      for (int k = 0; k < 8; k++)
         for (int i = 0; i < DIM; i++) begin
            mem_a[k][i] = BITS'(k + 1);
            mem_b[k][i] = BITS'(k + 1);
         end
      start_job(3, s);
      r.cyc = s + 3 + 2 * DIM + 2;
      for (int i = 0; i < DIM * DIM; i++) r.c[i] = 16'd14;
      res_q.push_back(r);
      wait_drain();

      // Signed full-result job, K=4, with -128 corner operands.
      for (int k = 0; k < 4; k++)
         for (int i = 0; i < DIM; i++) begin
            mem_a[k][i] = BITS'(ta[i][k]);
            mem_b[k][i] = BITS'(tb[k][i]);
         end
      start_job(4, s);
      r.cyc = s + 4 + 2 * DIM + 2;
      for (int i = 0; i < DIM; i++)
         for (int j = 0; j < DIM; j++) begin
            sum = '0;
            for (int k = 0; k < 4; k++) begin
               p   = 16'(ta[i][k] * tb[k][j]);
               sum = sum + p;
            end
            r.c[i*DIM+j] = sum;
         end
      res_q.push_back(r);
      wait_drain();

      // K=0: immediate done, no clear, reads or enable.
      start_job(0, s);
      wait_drain();

      // start held high, K=2: accepted every 13 cycles; starts in busy/DONE ignored.
      s = cyc;
      start = 1'b1;
      k_len = 16'd2;
      push_job(s, 2, 1000);
      push_job(s + 13, 2, 1000);
      push_job(s + 26, 2, 1000);
      repeat (27) @(posedge clk);
      #1;
      start = 1'b0;
      wait_drain();

      // Reset during DRAIN: job is lost, no done, outputs return to reset values.
      s = cyc;
      start = 1'b1;
      k_len = 16'd3;
      push_job(s, 3, 8);
      push_idle(s + 9, 20);
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      wait_drain();

      // Fresh job after the aborted one runs normally.
      start_job(2, s);
      wait_drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
      $fatal(1, "watchdog");
   end

endmodule
